// File: rtl/arm7_pkg.sv
// Shared ARM7 definitions: processor mode codes, register-bank indices,
// the operand-fetch sequencer state type and the read-list entry format.
package arm7_pkg;

    localparam logic [2:0] MODE_USR = 3'b000;
    localparam logic [2:0] MODE_SYS = 3'b001;
    localparam logic [2:0] MODE_FIQ = 3'b010;
    localparam logic [2:0] MODE_IRQ = 3'b011;
    localparam logic [2:0] MODE_SVC = 3'b100;
    localparam logic [2:0] MODE_ABT = 3'b101;
    localparam logic [2:0] MODE_UND = 3'b110;

    localparam logic [2:0] BANK_USR = 3'd0;  // shared by USR and SYS
    localparam logic [2:0] BANK_FIQ = 3'd1;
    localparam logic [2:0] BANK_IRQ = 3'd2;
    localparam logic [2:0] BANK_SVC = 3'd3;
    localparam logic [2:0] BANK_ABT = 3'd4;
    localparam logic [2:0] BANK_UND = 3'd5;

    localparam logic [31:0] PC_OFFSET_DEFAULT = 32'd8;
    localparam logic [3:0]  REG_PC            = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DONE
    } fetch_state_t;

    // One register-file read: target store, bank, index and the operand
    // slot (0 = Rn/PSR, 1 = Rm, 2 = Rs) that receives the returned data.
    typedef struct packed {
        logic       psr;
        logic [2:0] bank;
        logic [3:0] idx;
        logic [1:0] slot;
    } rd_entry_t;

    // Bank owning the mode's private registers (r13/r14, SPSR).
    // USR, SYS and the undefined code all resolve to the user bank.
    function automatic logic [2:0] mode_bank(input logic [2:0] mode);
        case (mode)
            MODE_FIQ: mode_bank = BANK_FIQ;
            MODE_IRQ: mode_bank = BANK_IRQ;
            MODE_SVC: mode_bank = BANK_SVC;
            MODE_ABT: mode_bank = BANK_ABT;
            MODE_UND: mode_bank = BANK_UND;
            default:  mode_bank = BANK_USR;
        endcase
    endfunction

endpackage

// File: rtl/reg_operand_fetch_if.sv
// Decode-side request, register-file read port and execute-side result
// bundle of the operand fetch sequencer.
interface reg_operand_fetch_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_mask;
    logic [3:0]  req_rn;
    logic [3:0]  req_rm;
    logic [3:0]  req_rs;
    logic        req_psr;
    logic        req_spsr;
    logic [2:0]  mode;
    logic [31:0] pc_value;

    logic        rf_rd_en;
    logic        rf_rd_psr;
    logic [2:0]  rf_rd_bank;
    logic [3:0]  rf_rd_reg;
    logic [31:0] rf_rd_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;

    // The sequencer itself.
    modport slave (
        input  req_valid, req_mask, req_rn, req_rm, req_rs, req_psr, req_spsr,
               mode, pc_value, rf_rd_data, out_ready,
        output req_ready, rf_rd_en, rf_rd_psr, rf_rd_bank, rf_rd_reg,
               out_valid, op_a, op_b, op_c
    );

    // Surroundings: decode, register file and execute.
    modport master (
        output req_valid, req_mask, req_rn, req_rm, req_rs, req_psr, req_spsr,
               mode, pc_value, rf_rd_data, out_ready,
        input  req_ready, rf_rd_en, rf_rd_psr, rf_rd_bank, rf_rd_reg,
               out_valid, op_a, op_b, op_c
    );

endinterface

// File: rtl/reg_bank_map.sv
// Maps (mode, register index) to the physical bank holding that register.
// Shared with the register file's write path so both ports bank alike.
module reg_bank_map
    import arm7_pkg::*;
(
    input  logic [2:0] mode,
    input  logic [3:0] reg_idx,
    output logic [2:0] bank
);

    // r0-r7 unbanked, r8-r12 banked for FIQ only, r13/r14 banked per mode.
    always_comb begin
        // NOTE: default first so every path assigns bank and no latch is inferred.
        bank = BANK_USR;
        if (reg_idx >= 4'd13) begin
            bank = mode_bank(mode);
        end else if (reg_idx >= 4'd8 && mode == MODE_FIQ) begin
            bank = BANK_FIQ;
        end
    end

endmodule

// File: rtl/reg_operand_fetch.sv
// Read-side operand sequencer for the banked ARM7 register file: turns one
// decode request into back-to-back single-port reads and returns all
// operands together on a valid/ready output.
module reg_operand_fetch
    import arm7_pkg::*;
#(
    parameter logic [31:0] PC_OFFSET = PC_OFFSET_DEFAULT
)
(
    input  logic                 clk,
    input  logic                 rst,
    reg_operand_fetch_if.slave   bus
);

    fetch_state_t state;
    logic         ready_q;
    logic         out_valid_q;
    logic         rd_en_q;
    rd_entry_t    rd_q;         // read currently presented to the register file
    logic [1:0]   ptr_q;        // next read-list entry to issue
    logic         cap_pend_q;   // rf_rd_data carries a requested value this cycle
    logic [1:0]   cap_slot_q;   // operand slot that value belongs to
    logic [31:0]  ops_q [3];

    rd_entry_t    list_q [3];
    logic [1:0]   count_q;

    rd_entry_t    list_d [3];
    logic [1:0]   count_d;
    logic [31:0]  init_d [3];
    logic [31:0]  pc_plus;
    logic [3:0]   idx_in  [3];
    logic [2:0]   bank_in [3];
    logic         accept;

    assign idx_in[0] = bus.req_rn;
    assign idx_in[1] = bus.req_rm;
    assign idx_in[2] = bus.req_rs;
    assign pc_plus   = bus.pc_value + PC_OFFSET;
    assign accept    = (state == ST_IDLE) && bus.req_valid && !rst;

    // Banks are resolved from the mode presented with the request, which is
    // exactly the mode latched at acceptance.
    reg_bank_map u_map_rn (.mode(bus.mode), .reg_idx(bus.req_rn), .bank(bank_in[0]));
    reg_bank_map u_map_rm (.mode(bus.mode), .reg_idx(bus.req_rm), .bank(bank_in[1]));
    reg_bank_map u_map_rs (.mode(bus.mode), .reg_idx(bus.req_rs), .bank(bank_in[2]));

    // Build the ordered read list and the preset operand values for a request.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            list_d[i] = '0;
            init_d[i] = '0;
        end
        count_d = 2'd0;
        if (bus.req_psr) begin
            if (!bus.req_spsr) begin
                list_d[0] = '{psr: 1'b1, bank: BANK_USR, idx: REG_PC, slot: 2'd0};
                count_d   = 2'd1;
            end else if (mode_bank(bus.mode) != BANK_USR) begin
                list_d[0] = '{psr: 1'b1, bank: mode_bank(bus.mode), idx: REG_PC, slot: 2'd0};
                count_d   = 2'd1;
            end
            // SPSR in a mode without one reads nothing and returns zero.
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bus.req_mask[i]) begin
                    if (idx_in[i] == REG_PC) begin
                        init_d[i] = pc_plus;
                    end else begin
                        list_d[count_d] = '{psr: 1'b0, bank: bank_in[i], idx: idx_in[i], slot: 2'(i)};
                        count_d         = count_d + 2'd1;
                    end
                end
            end
        end
    end

    // Hold the read list for the in-flight request.
    always_ff @(posedge clk) begin
        // NOTE: plain storage, only read after an accept has written it, so it needs no reset.
        if (accept) begin
            list_q  <= list_d;
            count_q <= count_d;
        end
    end

    // Sequencer FSM: accept, issue reads, capture data, present operands.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_q        <= '0;
            ptr_q       <= 2'd0;
            cap_pend_q  <= 1'b0;
            cap_slot_q  <= 2'd0;
            for (int i = 0; i < 3; i++) ops_q[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        ready_q    <= 1'b0;
                        cap_pend_q <= 1'b0;
                        ops_q      <= init_d;
                        if (count_d != 2'd0) begin
                            state   <= ST_READ;
                            rd_en_q <= 1'b1;
                            rd_q    <= list_d[0];
                            ptr_q   <= 2'd1;
                        end else begin
                            state       <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end

                ST_READ: begin
                    cap_pend_q <= rd_en_q;
                    cap_slot_q <= rd_q.slot;
                    if (rd_en_q && (ptr_q < count_q)) begin
                        rd_q  <= list_q[ptr_q];
                        ptr_q <= ptr_q + 2'd1;
                    end else begin
                        rd_en_q <= 1'b0;
                        rd_q    <= '0;
                    end
                    if (cap_pend_q) begin
                        ops_q[cap_slot_q] <= bus.rf_rd_data;
                        // No read outstanding behind this one: operands are complete.
                        if (!rd_en_q) begin
                            state       <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is masked by rst so it is low throughout reset yet high in the
    // very first cycle after it.
    assign bus.req_ready  = ready_q & ~rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.rf_rd_en   = rd_en_q;
    assign bus.rf_rd_psr  = rd_q.psr;
    assign bus.rf_rd_bank = rd_q.bank;
    assign bus.rf_rd_reg  = rd_q.idx;
    assign bus.op_a       = ops_q[0];
    assign bus.op_b       = ops_q[1];
    assign bus.op_c       = ops_q[2];

endmodule

// File: doc/reg_operand_fetch.md
# reg_operand_fetch

Read-side sequencer for the banked ARM7 register file. It accepts an operand request (up to three register indices, or a PSR read), issues one single-ported synchronous read per cycle with the correct mode bank, and substitutes PC+8 for r15. It returns all operands together on a valid/ready output. It sits between decode and execute, opposite the register file's write port.

## Interface
Parameters:
- PC_OFFSET, 8, value added to the captured PC when r15 is an operand.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request
- req_mask  in  3  operands needed: bit0 Rn, bit1 Rm, bit2 Rs
- req_rn, req_rm, req_rs  in  4 each  register indices
- req_psr  in  1  PSR read (MRS); req_mask ignored
- req_spsr  in  1  with req_psr: 1 = SPSR, 0 = CPSR
- mode  in  3  current mode (USR 000, SYS 001, FIQ 010, IRQ 011, SVC 100, ABT 101, UND 110)
- pc_value  in  32  current PC
- rf_rd_en  out  1  read strobe
- rf_rd_psr  out  1  read targets the PSR store
- rf_rd_bank  out  3  bank index 0..5 (USR/SYS, FIQ, IRQ, SVC, ABT, UND)
- rf_rd_reg  out  4  register index
- rf_rd_data  in  32  read data, valid the cycle after rf_rd_en
- out_valid  out  1  operands ready
- out_ready  in  1  consumer accepts
- op_a, op_b, op_c  out  32 each  Rn, Rm, Rs values (PSR value on op_a)

## Operation
- States: IDLE, READ, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the indices, mask, mode, and pc_value. Compute the read list in order Rn, Rm, Rs, skipping unmasked operands and r15.
- r15 operands take latched pc_value+PC_OFFSET (mod 2^32). No read is issued for them.
- Bank mapping uses the latched mode:
  - r0–r7: bank 0.
  - r8–r12: bank 1 if mode=FIQ, else bank 0.
  - r13/r14: bank by mode, with USR and SYS both mapping to 0.
  - Undefined mode codes (111) map to bank 0.
- PSR read:
  - CPSR: one read with rf_rd_psr=1, rf_rd_reg=15, rf_rd_bank=0.
  - SPSR in FIQ..UND: one read with bank 1..5.
  - SPSR in USR/SYS: no read, op_a=0.
- READ:
  - Issue one read per cycle until the list is exhausted.
  - Capture rf_rd_data into the matching op_* one cycle after each issue.
  - Enter DONE at the edge of the last capture.
- An empty read list goes IDLE→DONE directly.
- DONE:
  - out_valid=1; outputs stay stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - op_* of unrequested operands = 0.
- Mode changes or pc_value changes after acceptance have no effect on the in-flight request.

## Timing
- Cycle T is the request handshake cycle. n is the number of reads required (0..3).
- Reads are issued in cycles T+1..T+n, one per cycle, back-to-back.
- out_valid rises in cycle T+n+2 for n≥1, and in T+1 for n=0.
- Output handshake in cycle D: out_valid=0 and req_ready=1 in D+1. There is no accept in the same cycle as the output handshake.
- rf_rd_en is never high outside READ.
- Reset values: req_ready=0 during reset, then 1 in the first cycle after reset. rf_rd_en=0, rf_rd_psr=0, rf_rd_bank=0, rf_rd_reg=0, out_valid=0, op_a=op_b=op_c=0.
- Reset mid-operation:
  - Abort immediately; the state returns to IDLE.
  - rf_rd_data arriving the cycle after reset is ignored.
- Duplicate indices (e.g. Rn=Rm) are read twice. There is no forwarding or merging.

## Structure
- Shared package arm7_pkg holds:
  - the mode encodings (MODE_USR..MODE_UND);
  - the bank index constants;
  - PC_OFFSET default;
  - the state typedef.
- Sub-module reg_bank_map (combinational: mode, reg → bank) is reused by the register file's write path so both ends agree on banking.

## Test plan
- USR mode, mask=011, Rn=r3, Rm=r13:
  - reads (bank0,r3) at T+1 and (bank0,r13) at T+2;
  - out_valid at T+4 with op_a/op_b = returned data, op_c=0.
- FIQ mode, mask=111, Rn=r9, Rm=r15, Rs=r14, pc_value=0x100:
  - reads (1,r9) then (1,r14);
  - op_b=0x108; out_valid at T+4.
- mask=010, Rm=r15, pc_value=0xFFFFFFFC:
  - no rf_rd_en; out_valid at T+1; op_b=0x00000004.
- MRS:
  - req_spsr=1 in SVC issues a PSR read with bank 3, and op_a = returned data;
  - req_spsr=1 in USR issues no read, and op_a=0 at T+1.
- Backpressure and mode change:
  - out_ready held 0 for 5 cycles: outputs stable, req_ready=0, req_valid ignored;
  - a mode change mid-READ does not alter rf_rd_bank.
- Reset mid-operation:
  - rst asserted at T+2 of a 3-read request;
  - next cycle: rf_rd_en=0, out_valid=0, ops=0, req_ready=1 once rst deasserts.
